// File: rtl/operand_stage.sv
// ---------------------------------------------------------------------------
// operand_stage
//   Upstream operand-capture stage for the combinational datapath. Tuples
//   (in1, in2, sel) are accepted over a valid/ready handshake into a small
//   circular buffer. The oldest tuple is presented as op1/op2/sel_r with its
//   own valid/ready handshake, so the datapath only ever sees registered
//   operands.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active low
//   flush     synchronous clear of every buffered entry (wins over push/pop)
//   in_valid  producer has a tuple         in_ready  stage accepts this cycle
//   in1/in2   operands                     sel       operation select
//   op_valid  head tuple valid             op_ready  consumer takes the head
//   op1/op2   head operands                sel_r     head select
//   level     number of entries held
//
// Optional build macro OPERAND_STATS_EN adds:
//   xfer_cnt  saturating count of completed pops
//   stall_cnt saturating count of cycles with in_valid=1 and in_ready=0
// ---------------------------------------------------------------------------
module operand_stage #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in1,
    input  logic [WIDTH-1:0]         in2,
    input  logic [SEL_W-1:0]         sel,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [WIDTH-1:0]         op1,
    output logic [WIDTH-1:0]         op2,
    output logic [SEL_W-1:0]         sel_r,
`ifdef OPERAND_STATS_EN
    output logic [15:0]              xfer_cnt,
    output logic [15:0]              stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = 2 * WIDTH + SEL_W;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             alive;    // low in reset, high from the first edge after release
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    // Pointers carry a wrap bit: equal means empty, differing only in the
    // wrap bit means full.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Decoded from registered state plus flush only; never from in_valid or
    // op_ready, so a full stage that pops this cycle still refuses a push.
    assign in_ready = alive && !full && !flush;
    assign op_valid = !empty;

    assign push = in_valid && in_ready;
    assign pop  = op_valid && op_ready && !flush;

    assign level = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            alive  <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: an entry is only visible once the pointers say
    // it has been written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {in1, in2, sel};
    end

    // Head is read from the register array and masked to zero when empty,
    // which gives the zero outputs after reset and flush without touching
    // the storage itself. It cannot change while stalled because neither
    // rd_ptr nor the head entry moves without a pop.
    assign head = mem[rd_ptr[AW-1:0]];
    assign {op1, op2, sel_r} = op_valid ? head : '0;

`ifdef OPERAND_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && xfer_cnt != 16'hFFFF)
                xfer_cnt <= xfer_cnt + 16'd1;
            if (in_valid && !in_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_operand_stage
//   Directed steps followed by random traffic. A queue-based model of the
//   stage predicts every output; each edge is followed by a full comparison.
// ---------------------------------------------------------------------------
module tb_operand_stage;

    localparam int WIDTH = 8;
    localparam int SEL_W = 2;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             op_ready = 1'b0;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic [SEL_W-1:0] sel = '0;
    logic             in_ready;
    logic             op_valid;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [SEL_W-1:0] sel_r;
    logic [$clog2(DEPTH):0] level;
`ifdef OPERAND_STATS_EN
    logic [15:0]      xfer_cnt;
    logic [15:0]      stall_cnt;
`endif

    operand_stage #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .sel(sel),
        .op_valid(op_valid), .op_ready(op_ready),
        .op1(op1), .op2(op2), .sel_r(sel_r),
`ifdef OPERAND_STATS_EN
        .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt),
`endif
        .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SEL_W-1:0] s;
    } tup_t;

    tup_t q[$];
    bit   alive = 1'b0;
    int   m_xfer = 0;
    int   m_stall = 0;
    int   checks = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        tup_t h;
        bit   ov;
        bit   rdy;
        ov  = (q.size() != 0);
        h   = '{a: '0, b: '0, s: '0};
        if (ov) h = q[0];
        rdy = alive && (q.size() < DEPTH) && !flush;
        chk({tag, ".op_valid"}, 32'(op_valid), 32'(ov));
        chk({tag, ".level"},    32'(level),    32'(q.size()));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".op1"},      32'(op1),      32'(h.a));
        chk({tag, ".op2"},      32'(op2),      32'(h.b));
        chk({tag, ".sel_r"},    32'(sel_r),    32'(h.s));
`ifdef OPERAND_STATS_EN
        chk({tag, ".xfer_cnt"},  32'(xfer_cnt),  32'(m_xfer));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    // One clock edge: advance the model from the inputs held across the edge,
    // then compare everything shortly after the edge.
    task automatic tick(input string tag);
        bit rdy;
        bit psh;
        bit pp;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            alive   = 1'b0;
            m_xfer  = 0;
            m_stall = 0;
        end else begin
            rdy = alive && (q.size() < DEPTH) && !flush;
            psh = in_valid && rdy;
            pp  = (q.size() > 0) && op_ready && !flush;
            if (flush) begin
                q.delete();
                m_xfer  = 0;
                m_stall = 0;
            end else begin
                if (in_valid && !rdy && m_stall < 65535) m_stall++;
                if (pp) begin
                    void'(q.pop_front());
                    if (m_xfer < 65535) m_xfer++;
                end
                if (psh) q.push_back('{a: in1, b: in2, s: sel});
            end
            alive = 1'b1;
        end
        #1 check_all(tag);
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [SEL_W-1:0] s, input bit r);
        in_valid = v;
        in1      = a;
        in2      = b;
        sel      = s;
        op_ready = r;
    endtask

    task automatic drive_rand(input bit v, input bit r);
        drive(v, WIDTH'($urandom), WIDTH'($urandom), SEL_W'($urandom), r);
    endtask

    initial begin
        // Reset state
        #3 check_all("reset");
        tick("rst_hold");
        rst = 1'b1;
        tick("release");
        chk("in_ready_after_release", 32'(in_ready), 32'd1);

        // Single push, then hold with op_ready=0
        drive(1'b1, 8'h12, 8'h34, 2'b01, 1'b0);
        tick("t1_push");
        chk("t1_op1", 32'(op1), 32'h12);
        chk("t1_op2", 32'(op2), 32'h34);
        chk("t1_sel", 32'(sel_r), 32'h1);
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
        repeat (5) begin
            tick("t1_hold");
            chk("t1_hold_op1", 32'(op1), 32'h12);
        end
        op_ready = 1'b1;
        tick("t1_drain");
        op_ready = 1'b0;

        // Fill to DEPTH, 5th tuple refused, then full+pop behaviour
        for (int v = 1; v <= 4; v++) begin
            drive(1'b1, WIDTH'(v), WIDTH'(v) ^ 8'hA5, SEL_W'(v), 1'b0);
            tick("fill");
        end
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 8'd5, 8'd5 ^ 8'hA5, 2'd1, 1'b0);
        tick("fill_refuse");
        tick("fill_refuse");
        chk("refuse_level", 32'(level), 32'd4);
        op_ready = 1'b1;
        tick("full_pop");
        chk("full_pop_level", 32'(level), 32'd3);
        chk("full_pop_head", 32'(op1), 32'd2);
        tick("push_pop");
        chk("push_pop_level", 32'(level), 32'd3);
        chk("push_pop_head", 32'(op1), 32'd3);
        in_valid = 1'b0;
        tick("drain");
        chk("drain_head4", 32'(op1), 32'd4);
        tick("drain");
        chk("drain_head5", 32'(op1), 32'd5);
        tick("drain");
        chk("drain_empty", 32'(op_valid), 32'd0);
        op_ready = 1'b0;

        // Steady push+pop at level 2 across several wraps
        repeat (2) begin
            drive_rand(1'b1, 1'b0);
            tick("pp_prime");
        end
        repeat (14) begin
            drive_rand(1'b1, 1'b1);
            tick("pp_steady");
            chk("pp_level", 32'(level), 32'd2);
        end
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
        tick("pp_drain");
        tick("pp_drain");
        op_ready = 1'b0;

        // Flush at level 3 with push and pop requested
        repeat (3) begin
            drive_rand(1'b1, 1'b0);
            tick("fl_fill");
        end
        drive_rand(1'b1, 1'b1);
        flush = 1'b1;
        tick("flush");
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_op1", 32'(op1), 32'd0);
        flush = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
        tick("post_flush");

        // Asynchronous reset mid-stream at level 2
        repeat (2) begin
            drive_rand(1'b1, 1'b0);
            tick("ar_fill");
        end
        in_valid = 1'b0;
        rst = 1'b0;
        q.delete();
        alive   = 1'b0;
        m_xfer  = 0;
        m_stall = 0;
        #1 check_all("async_rst");
        chk("async_rst_level", 32'(level), 32'd0);
        tick("ar_hold");
        rst = 1'b1;
        tick("ar_release");
        drive(1'b1, 8'h77, 8'h88, 2'b11, 1'b0);
        tick("ar_push");
        chk("ar_push_op1", 32'(op1), 32'h77);
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
        tick("ar_drain");
        op_ready = 1'b0;

`ifdef OPERAND_STATS_EN
        // Counters: 3 stalled cycles then 2 pops
        flush = 1'b1;
        tick("st_clear");
        flush = 1'b0;
        repeat (4) begin
            drive_rand(1'b1, 1'b0);
            tick("st_fill");
        end
        repeat (3) tick("st_stall");
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
        repeat (2) tick("st_pop");
        chk("stall_cnt3", 32'(stall_cnt), 32'd3);
        chk("xfer_cnt2", 32'(xfer_cnt), 32'd2);
        repeat (2) tick("st_drain");
        op_ready = 1'b0;
`endif

        // Random traffic with occasional flush
        repeat (400) begin
            drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 19) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
